// File: rtl/router_input_port.sv
// NoC router input port: DEPTH-entry flit FIFO, XY route computation for packet heads,
// one-hot output-port request to the switch allocator and credit return upstream.
module router_input_port #(
    parameter int FLIT_WIDTH = 76,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 4,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic                  credit_out,
    output logic [4:0]            req,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  err,
    output logic                  fsm_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    // Valid/ready style handshake: the allocator's grant acts as "ready" and is only
    // honoured while req != 0; a transfer happens on the rising edge where both hold.
    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    state_t                state;
    logic [4:0]            route_q;

    logic [FLIT_WIDTH-1:0] head;
    logic [1:0]            head_type;
    logic [COORD_W-1:0]    dst_x, dst_y;
    logic [4:0]            head_route;
    logic                  empty, full, head_bearing;
    logic                  fwd, discard, deq, enq, overflow;

    assign head         = mem[rd_ptr];
    assign head_type    = head[FLIT_WIDTH-1:FLIT_WIDTH-2];
    assign dst_x        = head[FLIT_WIDTH-3 -: COORD_W];
    assign dst_y        = head[FLIT_WIDTH-3-COORD_W -: COORD_W];
    assign head_bearing = head_type[0];
    assign empty        = (count == '0);
    assign full         = (count == FULL_COUNT);

    always_comb begin
        head_route = 5'b00001;
        if (dst_x > CX)      head_route = 5'b01000;
        else if (dst_x < CX) head_route = 5'b10000;
        else if (dst_y > CY) head_route = 5'b00010;
        else if (dst_y < CY) head_route = 5'b00100;
    end

    always_comb begin
        req = 5'b00000;
        if (!empty) begin
            if (state == ACTIVE)   req = route_q;
            else if (head_bearing) req = head_route;
        end
    end

    // A BODY/TAIL at the head while idle has no route; it is dropped without a grant.
    assign fwd       = grant && (req != 5'b00000);
    assign discard   = (state == IDLE) && !empty && !head_bearing;
    assign deq       = fwd || discard;
    assign enq       = in_valid && (!full || deq);
    assign overflow  = in_valid && full && !deq;
    assign out_valid = fwd;
    assign out_flit  = head;
    assign fsm_state = (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            route_q    <= 5'b00000;
            credit_out <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            credit_out <= deq;
            if (overflow || discard || (state == ACTIVE && fwd && head_bearing))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (fwd && head_type == T_HEAD) begin
                        route_q <= head_route;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fwd && head_type == T_TAIL) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// Randomized and directed bench for router_input_port at CUR=(1,1), checked against a
// queue-based packet model of the input port.
module tb_router_input_port;

    localparam int FW = 76;
    localparam int DEPTH = 4;
    localparam int CW = 4;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          credit_out;
    logic [4:0]    req;
    logic          grant;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          err;
    logic          fsm_state;

    router_input_port #(
        .FLIT_WIDTH(FW), .DEPTH(DEPTH), .COORD_W(CW), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
        .credit_out(credit_out), .req(req), .grant(grant), .out_valid(out_valid),
        .out_flit(out_flit), .err(err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Reference model state: buffered flits, packet-in-progress flag and its route.
    logic [FW-1:0] exp_q[$];
    logic          in_pkt;
    logic [4:0]    pkt_route;
    logic          err_m;
    logic          credit_due;
    int            credits_seen;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
        logic [95:0]   r;
        logic [FW-1:0] f;
        r = {$urandom(), $urandom(), $urandom()};
        f = r[FW-1:0];
        f[FW-1:FW-2]   = t;
        f[FW-3 -: CW]    = CW'(x);
        f[FW-3-CW -: CW] = CW'(y);
        return f;
    endfunction

    function automatic logic [4:0] route_of(input logic [FW-1:0] f);
        int x, y;
        x = int'(f[FW-3 -: CW]);
        y = int'(f[FW-3-CW -: CW]);
        if (x > 1) return 5'b01000;
        if (x < 1) return 5'b10000;
        if (y > 1) return 5'b00010;
        if (y < 1) return 5'b00100;
        return 5'b00001;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        in_pkt     = 1'b0;
        pkt_route  = 5'b0;
        err_m      = 1'b0;
        credit_due = 1'b0;
    endtask

    // One clock cycle: drive, check outputs at the negedge, advance the model at the posedge.
    task automatic cycle(input logic iv, input logic [FW-1:0] f, input logic g);
        logic [4:0] er;
        logic       emp, hb, fwd, disc, acc;
        logic [1:0] ht;
        in_valid = iv;
        in_flit  = f;
        grant    = g;
        @(negedge clk);
        emp = (exp_q.size() == 0);
        ht  = emp ? T_BODY : exp_q[0][FW-1 -: 2];
        hb  = !emp && (ht == T_HEAD || ht == T_SINGLE);
        if (emp)          er = 5'b0;
        else if (in_pkt)  er = pkt_route;
        else if (hb)      er = route_of(exp_q[0]);
        else              er = 5'b0;
        fwd  = g && (er != 5'b0);
        disc = !in_pkt && !emp && !hb;
        check("req", FW'(req), FW'(er));
        check("out_valid", FW'(out_valid), FW'(fwd));
        if (!emp) check("out_flit", out_flit, exp_q[0]);
        check("credit_out", FW'(credit_out), FW'(credit_due));
        check("err", FW'(err), FW'(err_m));
        if (credit_out) credits_seen++;
        @(posedge clk);
        acc = iv && (exp_q.size() < DEPTH || fwd || disc);
        if (iv && !acc) err_m = 1'b1;
        if (disc) err_m = 1'b1;
        if (in_pkt && fwd && hb) err_m = 1'b1;
        if (fwd) begin
            if (!in_pkt && ht == T_HEAD) begin
                in_pkt    = 1'b1;
                pkt_route = er;
            end else if (in_pkt && ht == T_TAIL) begin
                in_pkt = 1'b0;
            end
        end
        if (fwd || disc) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(f);
        credit_due = fwd || disc;
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_req", FW'(req), FW'(5'b0));
        check("rst_out_valid", FW'(out_valid), FW'(1'b0));
        check("rst_credit", FW'(credit_out), FW'(1'b0));
        check("rst_err", FW'(err), FW'(1'b0));
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
    endtask

    initial begin
        int pend;
        logic [FW-1:0] f;
        logic iv;
        rst = 1'b0; in_valid = 1'b0; in_flit = '0; grant = 1'b0;
        model_reset();
        credits_seen = 0;
        #3;
        check("init_req", FW'(req), FW'(5'b0));
        check("init_out_valid", FW'(out_valid), FW'(1'b0));
        check("init_credit", FW'(credit_out), FW'(1'b0));
        check("init_err", FW'(err), FW'(1'b0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;

        // Single-flit packet routed east
        f = mk(T_SINGLE, 3, 1);
        cycle(1'b1, f, 1'b0);
        check("single_req_east", FW'(req), FW'(5'b01000));
        check("single_out_flit", out_flit, f);
        cycle(1'b0, '0, 1'b1);
        check("single_credit", FW'(credit_out), FW'(1'b1));
        cycle(1'b0, '0, 1'b0);

        // Wormhole packet to the south, granted every other cycle
        credits_seen = 0;
        cycle(1'b1, mk(T_HEAD, 1, 0), 1'b0);
        cycle(1'b1, mk(T_BODY, 7, 7), 1'b0);
        cycle(1'b1, mk(T_BODY, 5, 2), 1'b0);
        cycle(1'b1, mk(T_TAIL, 0, 9), 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) check("worm_req_south", FW'(req), FW'(5'b00100));
            cycle(1'b0, '0, logic'(i % 2));
        end
        cycle(1'b0, '0, 1'b0);
        check("worm_credits", FW'(credits_seen), FW'(4));
        check("worm_err", FW'(err), FW'(1'b0));

        // Overflow: fifth flit into a full FIFO is dropped
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(T_SINGLE, i % 3, 2), 1'b0);
        check("ovf_err", FW'(err), FW'(1'b1));
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        // Full FIFO with simultaneous enqueue/dequeue, ten flits through the wrap
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(T_SINGLE, 2, i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(T_SINGLE, i % 3, (i + 1) % 3), 1'b1);
        check("full_simul_err", FW'(err), FW'(1'b0));
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Protocol error: stray BODY while idle
        do_reset();
        cycle(1'b1, mk(T_BODY, 2, 2), 1'b0);
        check("proto_req_zero", FW'(req), FW'(5'b0));
        cycle(1'b0, '0, 1'b1);
        check("proto_credit", FW'(credit_out), FW'(1'b1));
        check("proto_err", FW'(err), FW'(1'b1));
        cycle(1'b1, mk(T_HEAD, 1, 1), 1'b0);
        check("proto_req_local", FW'(req), FW'(5'b00001));
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk(T_TAIL, 0, 0), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Reset mid-packet with two flits buffered
        do_reset();
        cycle(1'b1, mk(T_HEAD, 2, 1), 1'b0);
        cycle(1'b1, mk(T_BODY, 0, 0), 1'b0);
        cycle(1'b1, mk(T_BODY, 0, 0), 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("mid_req_east", FW'(req), FW'(5'b01000));
        do_reset();
        cycle(1'b1, mk(T_SINGLE, 0, 1), 1'b0);
        check("post_rst_req_west", FW'(req), FW'(5'b10000));
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Random well-formed packet traffic
        do_reset();
        pend = 0;
        for (int i = 0; i < 400; i++) begin
            iv = (exp_q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
            f  = '0;
            if (iv) begin
                if (pend == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        f = mk(T_SINGLE, $urandom_range(0, 3), $urandom_range(0, 3));
                    end else begin
                        f = mk(T_HEAD, $urandom_range(0, 3), $urandom_range(0, 3));
                        pend = $urandom_range(1, 3);
                    end
                end else begin
                    pend--;
                    f = mk((pend == 0) ? T_TAIL : T_BODY, $urandom_range(0, 15), $urandom_range(0, 15));
                end
            end
            cycle(iv, f, logic'($urandom_range(0, 1)));
        end
        check("rand_clean_err", FW'(err), FW'(1'b0));

        // Random flit types, including protocol violations and overflow
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(logic'($urandom_range(0, 1)),
                  mk(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_input_port.md
# router_input_port

Per-port input stage of the NoC router: buffers incoming flits in a DEPTH-entry FIFO, computes the XY route for each packet head, and requests one output port from the switch allocator. Granted flits drive the matching crossbar input. One instance per router port (five per router). Each dequeued flit returns one credit upstream.

## Interface
- FLIT_WIDTH, 76: flit width; must be ≥ 2 + 2*COORD_W.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- COORD_W, 4: width of each mesh coordinate.
- CUR_X, 0: this router's X coordinate.
- CUR_Y, 0: this router's Y coordinate.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream flit present this cycle.
- in_flit  input  FLIT_WIDTH  upstream flit.
- credit_out  output  1  one-cycle pulse, one credit returned upstream.
- req  output  5  one-hot output-port request to the allocator. Bit 0 LOCAL, 1 NORTH, 2 SOUTH, 3 EAST, 4 WEST.
- grant  input  1  allocator grants this port this cycle; valid only while req ≠ 0.
- out_valid  output  1  out_flit is being forwarded this cycle (equals grant & (req ≠ 0)).
- out_flit  output  FLIT_WIDTH  FIFO head flit; feeds the crossbar data input.
- err  output  1  sticky protocol/overflow error.

## Operation
- Flit type field is flit[FLIT_WIDTH-1:FLIT_WIDTH-2]:
  - 00 = BODY
  - 01 = HEAD
  - 10 = TAIL
  - 11 = SINGLE (head and tail together).
- HEAD and SINGLE flits carry the destination:
  - dst_x = flit[FLIT_WIDTH-3 -: COORD_W]
  - dst_y = the next COORD_W bits below dst_x.
- XY routing, with coordinates compared unsigned:
  - dst_x > CUR_X → EAST; dst_x < CUR_X → WEST.
  - Otherwise, dst_y > CUR_Y → NORTH; dst_y < CUR_Y → SOUTH.
  - Otherwise → LOCAL.
- FIFO:
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
  - out_flit = mem[rd_ptr] combinationally; the value is don't-care when empty.
- Enqueue:
  - Accepted when in_valid and (count < DEPTH, or a dequeue occurs in the same cycle).
  - If in_valid arrives while full with no dequeue, the flit is dropped and err is set.
- State machine, two states:
  - IDLE:
    - Empty → req = 0.
    - Head is HEAD or SINGLE → req = route(head).
    - Head is BODY or TAIL → req = 0. The flit is discarded (dequeued, credit returned) and err is set.
    - On grant with a HEAD flit: latch route into route_q and go to ACTIVE.
    - On grant with a SINGLE flit: stay in IDLE.
  - ACTIVE:
    - req = route_q when non-empty, else 0.
    - The head flit is expected to be BODY or TAIL. A HEAD or SINGLE flit here is still forwarded, and err is set.
    - On grant with a TAIL flit: go to IDLE.
- Dequeue happens on grant & (req ≠ 0), or on the IDLE discard case. Any grant while req = 0 is ignored.
- err clears only on reset.

## Timing
- Reset values:
  - Pointers 0, count 0.
  - State IDLE, route_q 0.
  - credit_out 0, err 0.
  - req 0 and out_valid 0, because the FIFO is empty.
- Enqueue-to-request latency: a flit written at edge N is at the head in the cycle after N. If the FIFO was empty, req is asserted in that cycle.
- req, out_valid and out_flit are combinational from state and FIFO head. The dequeue takes effect at the next edge.
- credit_out is registered: it pulses in the cycle after each dequeue (including discards). At most one pulse per cycle.
- Back-to-back grants forward one flit per cycle. Throughput is 1 flit/cycle.
- Simultaneous enqueue and dequeue: count unchanged. This is legal at full and at empty+1.
- An asynchronous reset mid-packet aborts the packet immediately. FIFO contents are abandoned and no credits are returned.

## Test plan
- Single packet: CUR=(1,1). Enqueue SINGLE with dst=(3,1).
  - Next cycle: req=5'b01000 (EAST).
  - Grant: out_valid=1, out_flit equals the input flit.
  - One cycle later: credit_out=1.
- Wormhole: enqueue HEAD dst=(1,0), BODY, BODY, TAIL. Grant every other cycle.
  - req=5'b00100 (SOUTH) held through all four flits.
  - Returns to IDLE after TAIL.
  - Four credit pulses.
- Full/overflow (DEPTH=4): enqueue 4 flits with no grant. A 5th in_valid is dropped, err=1, count stays 4.
- Full with simultaneous dequeue: at count 4, in_valid and grant in the same cycle. Flit accepted, count stays 4, no err. Pointer wrap checked over 10 consecutive flits.
- Protocol error: in IDLE, enqueue a BODY flit.
  - req stays 0.
  - Flit discarded, credit_out pulses, err=1.
  - A following HEAD flit to (1,1) requests LOCAL (5'b00001).
- Reset mid-packet: assert rst=0 in ACTIVE with 2 flits buffered. Outputs immediately return to the reset values listed under Timing. After release, a new SINGLE flit routes correctly.
